mips_multicycle_ctrl: RTL
=========================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Next-generation MIPS control: a Moore FSM for a multi-cycle datapath that replaces the single-cycle opcode decoder.
//  Sequences FETCH/DECODE/EXEC/MEM/WB, waits on a memory ready handshake with timeout, and traps illegal opcodes.
//  Supports R-type, jr, lw, sw, addi, andi, beq, j and jal. Sits between the IR/memory interface and the datapath muxes.
// PARAMETERS
//  OP_W        6   opcode field width
//  FUNCT_W     6   funct field width
//  ALUOP_W     3   width of aluop to the ALU decoder
//  MEM_TIMEOUT 15  max consecutive mem_ready=0 cycles in a memory state before fault (>=1)
// PORTS
//  clk          in   1        single clock, rising edge
//  rst          in   1        reset: asynchronous, active-high
//  op           in   OP_W     IR[31:26], valid from DECODE onward
//  funct        in   FUNCT_W  IR[5:0]
//  zero         in   1        ALU zero flag, used in S_BRANCH
//  mem_ready    in   1        memory done this cycle (read data valid / write accepted)
//  mem_read     out  1        memory read strobe
//  mem_write    out  1        memory write strobe
//  i_or_d       out  1        0=PC addresses memory, 1=ALUOut
//  ir_write     out  1        latch instruction register
//  pc_write     out  1        unconditional PC load
//  pc_write_cond out 1        PC load if zero
//  pc_source    out  2        00 ALU, 01 ALUOut, 10 jump target, 11 rs (jr)
//  alu_src_a    out  1        0=PC, 1=rs
//  alu_src_b    out  2        00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2
//  aluop        out  ALUOP_W  000 R-funct, 001 add, 010 addi, 011 and, 110 sub
//  reg_dst      out  2        00 rt, 01 rd, 10 $31
//  reg_write    out  1        register file write enable
//  mem_to_reg   out  2        00 ALUOut, 01 MDR, 10 PC (link)
//  retire       out  1        1-cycle pulse on the last cycle of each instruction
//  fault        out  1        sticky: illegal opcode or memory timeout
//  fault_code   out  2        00 none, 01 illegal op, 10 mem timeout
// BEHAVIOUR
//  - rst asserted: state=S_FETCH, wait_cnt=0, fault=0, fault_code=00; ALL outputs forced 0 while rst=1.
//  - Outputs are pure functions of state (plus mem_ready, zero where noted); no output depends on op outside S_DECODE.
//  - S_FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, aluop=001; ir_write=pc_write=mem_ready; ->S_DECODE on mem_ready.
//  - S_DECODE: alu_src_a=0, alu_src_b=11, aluop=001 (branch target). Next by op: 000000 -> S_JR if funct=001000 else S_EXEC_R;
//    100011/101011 -> S_MEM_ADDR; 001000/001100 -> S_EXEC_I; 000100 -> S_BRANCH; 000010 -> S_JUMP; 000011 -> S_JAL; else -> S_FAULT (code 01).
//  - S_EXEC_R: alu_src_a=1, alu_src_b=00, aluop=000 -> S_WB_R.  S_WB_R: reg_dst=01, reg_write=1, mem_to_reg=00, retire -> S_FETCH.
//  - S_EXEC_I: alu_src_a=1, alu_src_b=10, aluop=010 (addi) / 011 (andi) -> S_WB_I. S_WB_I: reg_dst=00, reg_write=1, retire -> S_FETCH.
//  - S_MEM_ADDR: alu_src_a=1, alu_src_b=10, aluop=001 -> S_MEM_RD (lw) or S_MEM_WR (sw).
//  - S_MEM_RD: mem_read=1, i_or_d=1; on mem_ready -> S_WB_MEM. S_WB_MEM: reg_dst=00, mem_to_reg=01, reg_write=1, retire.
//  - S_MEM_WR: mem_write=1, i_or_d=1; on mem_ready retire -> S_FETCH. sw never asserts reg_write.
//  - S_BRANCH: alu_src_a=1, alu_src_b=00, aluop=110, pc_write_cond=1, pc_source=01, retire -> S_FETCH (PC loads only if zero).
//  - S_JUMP: pc_write=1, pc_source=10, retire. S_JAL: same plus reg_dst=10, mem_to_reg=10, reg_write=1 (same cycle, old PC+4 linked).
//  - S_JR: pc_write=1, pc_source=11, retire. jr never writes the register file.
//  - Handshake: strobes held constant in a memory state (FETCH, MEM_RD, MEM_WR) until mem_ready; no state change otherwise.
//  - wait_cnt: clears on entry to each memory state and on mem_ready; increments each mem_ready=0 cycle there; saturates.
//    When wait_cnt==MEM_TIMEOUT with mem_ready=0 -> S_FAULT (code 10). mem_ready in the same cycle wins over timeout.
//  - S_FAULT: all strobes 0, fault=1, absorbing until rst. fault_code latched on entry, never overwritten.
//  - rst mid-memory-access: strobes drop asynchronously; restart at S_FETCH with PC unchanged by this block.
// STRUCTURE
//  - mips_ctrl_pkg: opcode/funct localparams (OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_ANDI, OP_BEQ, OP_J, OP_JAL, FN_JR),
//    ALUOP_* codes, state enum (4-bit), FAULT_* codes.
//  - Sub-module mips_ctrl_wait_timer (MEM_TIMEOUT param): clear/inc/expired; FSM and output decode live in this module.
// TESTING
//  - lw, mem_ready low 2 cycles in FETCH and MEM_RD: FETCH x3, DECODE, MEM_ADDR, MEM_RD x3, WB_MEM; retire once, reg_write only in WB_MEM.
//  - beq with zero=1 then zero=0: pc_write_cond=1, pc_source=01 in BRANCH both times; reg_write=0 throughout.
//  - jal (op=000011): JAL cycle has pc_write=1, pc_source=10, reg_dst=10, mem_to_reg=10, reg_write=1.
//  - op=000000 funct=001000: S_JR, pc_source=11, reg_write=0; funct=100000 -> EXEC_R, WB_R reg_dst=01.
//  - op=111111: S_FAULT, fault=1, fault_code=01, strobes 0 for 20 cycles; rst returns to FETCH, fault=0.
//  - sw with mem_ready held 0: fault_code=10 after 15 wait cycles; rst asserted mid-MEM_RD -> mem_read=0 same cycle.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, ALU codes,
// FSM states, fault codes and the per-state control word.
package mips_ctrl_pkg;

    localparam int OP_W    = 6;
    localparam int FUNCT_W = 6;
    localparam int ALUOP_W = 3;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;

    localparam logic [FUNCT_W-1:0] FN_JR = 6'b001000;

    localparam logic [ALUOP_W-1:0] ALUOP_RFN  = 3'b000;
    localparam logic [ALUOP_W-1:0] ALUOP_ADD  = 3'b001;
    localparam logic [ALUOP_W-1:0] ALUOP_ADDI = 3'b010;
    localparam logic [ALUOP_W-1:0] ALUOP_AND  = 3'b011;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB  = 3'b110;

    localparam logic [1:0] FAULT_NONE        = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL_OP  = 2'b01;
    localparam logic [1:0] FAULT_MEM_TIMEOUT = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
        S_MEM_ADDR, S_MEM_RD, S_WB_MEM, S_MEM_WR,
        S_BRANCH, S_JUMP, S_JAL, S_JR, S_FAULT
    } state_e;

    // fetch_ld / retire_on_ready are qualified by mem_ready at the port.
    typedef struct packed {
        logic               mem_read;
        logic               mem_write;
        logic               i_or_d;
        logic               pc_write;
        logic               pc_write_cond;
        logic [1:0]         pc_source;
        logic               alu_src_a;
        logic [1:0]         alu_src_b;
        logic [ALUOP_W-1:0] aluop;
        logic [1:0]         reg_dst;
        logic               reg_write;
        logic [1:0]         mem_to_reg;
        logic               retire;
        logic               fetch_ld;
        logic               retire_on_ready;
    } ctrl_out_t;

    function automatic logic is_mem_state(state_e s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

    function automatic ctrl_out_t ctrl_for_state(state_e s, logic is_andi);
        ctrl_out_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
                c.aluop     = ALUOP_ADD;
                c.fetch_ld  = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_b = 2'b11;
                c.aluop     = ALUOP_ADD;
            end
            S_EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.aluop     = ALUOP_RFN;
            end
            S_WB_R: begin
                c.reg_dst   = 2'b01;
                c.reg_write = 1'b1;
                c.retire    = 1'b1;
            end
            S_EXEC_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.aluop     = is_andi ? ALUOP_AND : ALUOP_ADDI;
            end
            S_WB_I: begin
                c.reg_write = 1'b1;
                c.retire    = 1'b1;
            end
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.aluop     = ALUOP_ADD;
            end
            S_MEM_RD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_WB_MEM: begin
                c.mem_to_reg = 2'b01;
                c.reg_write  = 1'b1;
                c.retire     = 1'b1;
            end
            S_MEM_WR: begin
                c.mem_write       = 1'b1;
                c.i_or_d          = 1'b1;
                c.retire_on_ready = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.aluop         = ALUOP_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
                c.retire        = 1'b1;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
                c.retire    = 1'b1;
            end
            S_JAL: begin
                c.pc_write   = 1'b1;
                c.pc_source  = 2'b10;
                c.reg_dst    = 2'b10;
                c.mem_to_reg = 2'b10;
                c.reg_write  = 1'b1;
                c.retire     = 1'b1;
            end
            S_JR: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b11;
                c.retire    = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> IR/memory/datapath bundle. master = controller, slave = datapath side.
interface mips_multicycle_ctrl_if;
    import mips_ctrl_pkg::*;

    logic [OP_W-1:0]    op;
    logic [FUNCT_W-1:0] funct;
    logic               zero;
    logic               mem_ready;
    logic               mem_read;
    logic               mem_write;
    logic               i_or_d;
    logic               ir_write;
    logic               pc_write;
    logic               pc_write_cond;
    logic [1:0]         pc_source;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [ALUOP_W-1:0] aluop;
    logic [1:0]         reg_dst;
    logic               reg_write;
    logic [1:0]         mem_to_reg;
    logic               retire;
    logic               fault;
    logic [1:0]         fault_code;

    modport master (
        input  op, funct, zero, mem_ready,
        output mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
               pc_source, alu_src_a, alu_src_b, aluop, reg_dst, reg_write,
               mem_to_reg, retire, fault, fault_code
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
               pc_source, alu_src_a, alu_src_b, aluop, reg_dst, reg_write,
               mem_to_reg, retire, fault, fault_code
    );

endinterface

// File: rtl/mips_ctrl_wait_timer.sv
// Saturating count of consecutive mem_ready=0 cycles spent in a memory state.
module mips_ctrl_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expired
);
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (clear)
            wait_cnt_d = '0;
        else if (inc && (wait_cnt_q != CNT_MAX))
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wait_cnt_q <= '0;
        else
            wait_cnt_q <= wait_cnt_d;
    end

    assign expired = (wait_cnt_q == CNT_MAX);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for a multi-cycle MIPS datapath with memory-ready
// handshake, wait timeout and sticky illegal-op / timeout fault.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input logic                   clk,
    input logic                   rst,
    mips_multicycle_ctrl_if.master bus
);

    state_e     state_q, state_d;
    ctrl_out_t  ctrl_q, ctrl_d, ctrl_vis;
    logic       fault_q, fault_d;
    logic [1:0] fault_code_q, fault_code_d, fault_cause;
    logic       timer_clear, timer_inc, timer_expired;

    mips_ctrl_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .inc     (timer_inc),
        .expired (timer_expired)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        fault_cause = FAULT_NONE;
        unique case (state_q)
            S_FETCH:
                if (bus.mem_ready) state_d = S_DECODE;
                else if (timer_expired) begin
                    state_d     = S_FAULT;
                    fault_cause = FAULT_MEM_TIMEOUT;
                end
            S_DECODE:
                case (bus.op)
                    OP_RTYPE:        state_d = (bus.funct == FN_JR) ? S_JR : S_EXEC_R;
                    OP_LW, OP_SW:    state_d = S_MEM_ADDR;
                    OP_ADDI, OP_ANDI: state_d = S_EXEC_I;
                    OP_BEQ:          state_d = S_BRANCH;
                    OP_J:            state_d = S_JUMP;
                    OP_JAL:          state_d = S_JAL;
                    default: begin
                        state_d     = S_FAULT;
                        fault_cause = FAULT_ILLEGAL_OP;
                    end
                endcase
            S_EXEC_R:   state_d = S_WB_R;
            S_EXEC_I:   state_d = S_WB_I;
            S_MEM_ADDR: state_d = (bus.op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD, S_MEM_WR:
                if (bus.mem_ready) state_d = (state_q == S_MEM_RD) ? S_WB_MEM : S_FETCH;
                else if (timer_expired) begin
                    state_d     = S_FAULT;
                    fault_cause = FAULT_MEM_TIMEOUT;
                end
            S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP, S_JAL, S_JR:
                state_d = S_FETCH;
            S_FAULT:    state_d = S_FAULT;
            default:    state_d = S_FETCH;
        endcase

        fault_d      = fault_q | (state_d == S_FAULT);
        fault_code_d = fault_code_q;
        if ((state_d == S_FAULT) && (state_q != S_FAULT))
            fault_code_d = fault_cause;

        // Outputs are decoded from the next state so they come straight off flops;
        // op is only consulted here while leaving DECODE.
        ctrl_d = ctrl_for_state(state_d, bus.op == OP_ANDI);

        timer_clear = bus.mem_ready | (is_mem_state(state_d) && (state_d != state_q));
        timer_inc   = is_mem_state(state_q) & ~bus.mem_ready;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_FETCH;
            ctrl_q       <= ctrl_for_state(S_FETCH, 1'b0);
            fault_q      <= 1'b0;
            fault_code_q <= FAULT_NONE;
        end else begin
            state_q      <= state_d;
            ctrl_q       <= ctrl_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
        end
    end

    // ctrl_q holds the FETCH word through reset, so strobes are masked while rst is high.
    assign ctrl_vis = rst ? ctrl_out_t'('0) : ctrl_q;

    assign bus.mem_read      = ctrl_vis.mem_read;
    assign bus.mem_write     = ctrl_vis.mem_write;
    assign bus.i_or_d        = ctrl_vis.i_or_d;
    assign bus.ir_write      = ctrl_vis.fetch_ld & bus.mem_ready;
    assign bus.pc_write      = ctrl_vis.pc_write | (ctrl_vis.fetch_ld & bus.mem_ready);
    assign bus.pc_write_cond = ctrl_vis.pc_write_cond;
    assign bus.pc_source     = ctrl_vis.pc_source;
    assign bus.alu_src_a     = ctrl_vis.alu_src_a;
    assign bus.alu_src_b     = ctrl_vis.alu_src_b;
    assign bus.aluop         = ctrl_vis.aluop;
    assign bus.reg_dst       = ctrl_vis.reg_dst;
    assign bus.reg_write     = ctrl_vis.reg_write;
    assign bus.mem_to_reg    = ctrl_vis.mem_to_reg;
    assign bus.retire        = ctrl_vis.retire | (ctrl_vis.retire_on_ready & bus.mem_ready);
    assign bus.fault         = fault_q;
    assign bus.fault_code    = fault_code_q;

endmodule
